// File: rtl/mdu_iterative_if.sv
// mdu_iterative_if: request, HI/LO write/read and status signals of the
// iterative multiply/divide unit, bundled for the CPU execute stage.
interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             wr_en;
    logic             wr_hi;
    logic [WIDTH-1:0] wr_data;
    logic             rd_hi;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, in_a, in_b, wr_en, wr_hi, wr_data, rd_hi,
        input  rd_data, busy, done, div_zero
    );

    modport slave (
        input  start, op, in_a, in_b, wr_en, wr_hi, wr_data, rd_hi,
        output rd_data, busy, done, div_zero
    );
endinterface

// File: rtl/mdu_iterative.sv
// mdu_iterative: multiply/divide unit with HI/LO result registers.
// Multiplies hold the product for MUL_LAT cycles before committing; divides
// run a restoring divider (one quotient bit per cycle) followed by a sign
// fix-up cycle. A HI/LO write while busy aborts the operation.
// Optional build macro MDU_MACC_EN adds MADDU/MADD/MSUB (ops 5/6/7), which
// accumulate the product into {HI,LO} at the commit edge.
module mdu_iterative #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic           clk,
    input  logic           reset,
    mdu_iterative_if.slave bus
);
    localparam int W2      = 2 * WIDTH;
    localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MULT  = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
`ifdef MDU_MACC_EN
    localparam logic [2:0] OP_MADDU = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // committed results
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // operation temporaries
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             q_neg;
    logic             r_neg;
    logic             dz;
`ifdef MDU_MACC_EN
    logic [2:0]       op_q;
`endif

    // registered status pulses
    logic             done_q;
    logic             dz_q;

    // decode and control strobes
    logic             op_valid;
    logic             is_mul_op;
    logic             mul_signed;
    logic             a_neg;
    logic             b_neg;
    logic             cnt_zero;
    logic             accept;
    logic             commit_mul;
    logic             commit_fix;

    // divide step and multiply commit values
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_nxt;
    logic [W2-1:0]    acc_res;

    // Full-width product; signed operands are sign-extended so one
    // 2*WIDTH multiplier serves both signednesses.
    function automatic logic [W2-1:0] mul_full(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sgn);
        logic signed [W2-1:0] xa;
        logic signed [W2-1:0] xb;
        xa = sgn ? signed'({{WIDTH{a[WIDTH-1]}}, a}) : signed'({{WIDTH{1'b0}}, a});
        xb = sgn ? signed'({{WIDTH{b[WIDTH-1]}}, b}) : signed'({{WIDTH{1'b0}}, b});
        return unsigned'(xa * xb);
    endfunction

    // Two's-complement negate when neg is set: used both for taking
    // magnitudes at accept and for restoring signs in the fix-up cycle.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic op_supported(input logic [2:0] o);
`ifdef MDU_MACC_EN
        return (o != 3'd0);
`else
        return (o == OP_MULTU) || (o == OP_MULT) || (o == OP_DIVU) || (o == OP_DIV);
`endif
    endfunction

    // Decode of the incoming request
    always_comb begin
        op_valid   = op_supported(bus.op);
`ifdef MDU_MACC_EN
        is_mul_op  = (bus.op == OP_MULTU) || (bus.op == OP_MULT) || (bus.op == OP_MADDU)
                  || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
        mul_signed = (bus.op == OP_MULT) || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
`else
        is_mul_op  = (bus.op == OP_MULTU) || (bus.op == OP_MULT);
        mul_signed = (bus.op == OP_MULT);
`endif
        a_neg      = (bus.op == OP_DIV) && bus.in_a[WIDTH-1];
        b_neg      = (bus.op == OP_DIV) && bus.in_b[WIDTH-1];
        cnt_zero   = (cnt == '0);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and commit strobes; a HI/LO write always wins over
    // starting or finishing an operation
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        commit_mul = 1'b0;
        commit_fix = 1'b0;
        case (state)
            S_IDLE: begin
                if (!bus.wr_en && bus.start && op_valid) begin
                    accept = 1'b1;
                    if (is_mul_op) begin
                        state_nxt = S_MUL;
                    end else if (bus.in_b == '0) begin
                        state_nxt = S_FIX;
                    end else begin
                        state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (bus.wr_en) begin
                    state_nxt = S_IDLE;
                end else if (cnt_zero) begin
                    commit_mul = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            S_DIV: begin
                if (bus.wr_en) begin
                    state_nxt = S_IDLE;
                end else if (cnt_zero) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_IDLE;
                if (!bus.wr_en) begin
                    commit_fix = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits
    always_comb begin
        rem_sh  = {rem, quot[WIDTH-1]};
        diff    = rem_sh - {1'b0, dvs};
        borrow  = diff[WIDTH];
        rem_nxt = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    // Value written to {HI,LO} when a multiply commits
    always_comb begin
        acc_res = prod;
`ifdef MDU_MACC_EN
        case (op_q)
            OP_MADDU, OP_MADD: acc_res = {hi, lo} + prod;
            OP_MSUB:           acc_res = {hi, lo} - prod;
            default:           acc_res = prod;
        endcase
`endif
    end

    // Operand capture, divide iteration, HI/LO writes and result commits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            prod   <= '0;
            dvs    <= '0;
            quot   <= '0;
            rem    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz     <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
`ifdef MDU_MACC_EN
            op_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;

            if (accept) begin
`ifdef MDU_MACC_EN
                op_q <= bus.op;
`endif
                if (is_mul_op) begin
                    prod <= mul_full(bus.in_a, bus.in_b, mul_signed);
                    cnt  <= CNT_W'(MUL_LAT - 1);
                end else begin
                    quot  <= apply_sign(bus.in_a, a_neg);
                    dvs   <= apply_sign(bus.in_b, b_neg);
                    rem   <= '0;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    dz    <= (bus.in_b == '0);
                    cnt   <= CNT_W'(WIDTH - 1);
                end
            end else if (((state == S_MUL) || (state == S_DIV)) && !cnt_zero) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (state == S_DIV) begin
                rem  <= rem_nxt;
                quot <= {quot[WIDTH-2:0], ~borrow};
            end

            if (bus.wr_en) begin
                if (bus.wr_hi) begin
                    hi <= bus.wr_data;
                end else begin
                    lo <= bus.wr_data;
                end
            end else if (commit_mul) begin
                {hi, lo} <= acc_res;
                done_q   <= 1'b1;
            end else if (commit_fix) begin
                done_q <= 1'b1;
                if (dz) begin
                    dz_q <= 1'b1;
                end else begin
                    lo <= apply_sign(quot, q_neg);
                    hi <= apply_sign(rem, r_neg);
                end
            end
        end
    end

    assign bus.rd_data  = bus.rd_hi ? hi : lo;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed bench for mdu_iterative (WIDTH=32, MUL_LAT=5)
// with an operation-level reference model and a per-cycle compare process.
module tb_mdu_iterative;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;

    logic clk;
    logic reset;

    mdu_iterative_if #(.WIDTH(WIDTH)) bus ();

    mdu_iterative #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counters, stepped only by the compare process
    int n_total = 0;
    int n_bad   = 0;

    // literal-expectation mailbox from the stimulus to the compare process
    int          lit_req = 0;
    int          lit_ack = 0;
    string       lit_tag;
    logic [63:0] lit_act;
    logic [63:0] lit_exp;

    // reference model state
    bit [31:0] m_hi   = 0;
    bit [31:0] m_lo   = 0;
    int        m_left = 0;
    bit        m_done = 0;
    bit        m_divz = 0;
    bit        m_dz   = 0;
    int        m_kind = 0;
    bit [63:0] m_res  = 0;

    function automatic bit op_ok(input logic [2:0] op);
`ifdef MDU_MACC_EN
        return op != 3'd0;
`else
        return (op >= 3'd1) && (op <= 3'd4);
`endif
    endfunction

    // Result of an operation from plain arithmetic: product, or {rem,quot}
    function automatic logic [63:0] model_result(input logic [2:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        longint    sa;
        longint    sb;
        int        ia;
        int        ib;
        logic [31:0] q;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd1, 3'd5: return {32'b0, a} * {32'b0, b};
            3'd2, 3'd6, 3'd7: return 64'(sa * sb);
            3'd3: begin
                if (b == 0) return 64'd0;
                q = a / b;
                r = a % b;
                return {r, q};
            end
            3'd4: begin
                if (b == 0) return 64'd0;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    q = 32'h80000000;
                    r = 32'h0;
                end else begin
                    q = 32'(ia / ib);
                    r = 32'(ia % ib);
                end
                return {r, q};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Reference model: tracks committed HI/LO and how many busy cycles remain
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            m_done = 0;
            m_divz = 0;
            if (!reset) begin
                m_hi   = 0;
                m_lo   = 0;
                m_left = 0;
            end else if (bus.wr_en) begin
                if (bus.wr_hi) m_hi = bus.wr_data;
                else           m_lo = bus.wr_data;
                m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    if (m_dz)             m_divz = 1;
                    else if (m_kind == 1) {m_hi, m_lo} = {m_hi, m_lo} + m_res;
                    else if (m_kind == 2) {m_hi, m_lo} = {m_hi, m_lo} - m_res;
                    else                  {m_hi, m_lo} = m_res;
                end
            end else if (bus.start && op_ok(bus.op)) begin
                m_res  = model_result(bus.op, bus.in_a, bus.in_b);
                m_dz   = (bus.op == 3'd3 || bus.op == 3'd4) && (bus.in_b == 0);
                m_kind = (bus.op == 3'd5 || bus.op == 3'd6) ? 1 : (bus.op == 3'd7) ? 2 : 0;
                if (bus.op == 3'd3 || bus.op == 3'd4) m_left = m_dz ? 1 : WIDTH + 1;
                else                                  m_left = MUL_LAT;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare process: DUT against the model every cycle, plus literals
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 64'(bus.busy), 64'(m_left > 0));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("div_zero", 64'(bus.div_zero), 64'(m_divz));
            chk("rd_data", 64'(bus.rd_data), 64'(bus.rd_hi ? m_hi : m_lo));
            if (lit_req != lit_ack) begin
                chk(lit_tag, lit_act, lit_exp);
                lit_ack = lit_req;
            end
        end
    end

    task automatic lit(input string tag, input logic [63:0] act, input logic [63:0] exp);
        lit_tag = tag;
        lit_act = act;
        lit_exp = exp;
        lit_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input bit sel_hi, input logic [31:0] exp);
        bus.rd_hi = sel_hi;
        #1;
        lit(tag, 64'(bus.rd_data), 64'(exp));
    endtask

    task automatic write_reg(input bit sel_hi, input logic [31:0] data);
        @(posedge clk);
        #2;
        bus.wr_en   = 1'b1;
        bus.wr_hi   = sel_hi;
        bus.wr_data = data;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    // Present a request for one cycle; returns just after the accepting edge
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        bus.op    = op;
        bus.in_a  = a;
        bus.in_b  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count busy cycles until idle (bounded); report done/div_zero at the end
    task automatic wait_idle(output int nbusy, output bit done_end, output bit dz_end);
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) break;
            nbusy++;
            @(posedge clk);
            #1;
        end
        done_end = bus.done;
        dz_end   = bus.div_zero;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output bit done_end, output bit dz_end);
        start_op(op, a, b);
        wait_idle(nbusy, done_end, dz_end);
    endtask

    initial begin
        int nb;
        int nd;
        bit de;
        bit dz;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.in_a    = '0;
        bus.in_b    = '0;
        bus.wr_en   = 1'b0;
        bus.wr_hi   = 1'b0;
        bus.wr_data = '0;
        bus.rd_hi   = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // reset state
        lit("reset_busy", 64'(bus.busy), 64'd0);
        chk_reg("reset_hi", 1'b1, 32'h0);
        chk_reg("reset_lo", 1'b0, 32'h0);

        // MULT -1 * 2, LO shown during busy
        bus.rd_hi = 1'b0;
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, nb, de, dz);
        lit("mult_busy_cycles", 64'(nb), 64'd5);
        lit("mult_done", 64'(de), 64'd1);
        @(posedge clk);
        #1;
        lit("mult_done_one_cycle", 64'(bus.done), 64'd0);
        chk_reg("mult_hi", 1'b1, 32'hFFFFFFFF);
        chk_reg("mult_lo", 1'b0, 32'hFFFFFFFE);

        // DIV -7 / 2
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, nb, de, dz);
        lit("div_busy_cycles", 64'(nb), 64'd33);
        lit("div_done", 64'(de), 64'd1);
        chk_reg("div_lo", 1'b0, 32'hFFFFFFFD);
        chk_reg("div_hi", 1'b1, 32'hFFFFFFFF);

        // DIVU 100 / 7
        run_op(3'd3, 32'd100, 32'd7, nb, de, dz);
        lit("divu_busy_cycles", 64'(nb), 64'd33);
        chk_reg("divu_lo", 1'b0, 32'd14);
        chk_reg("divu_hi", 1'b1, 32'd2);

        // divide by zero keeps HI/LO
        write_reg(1'b1, 32'h1234);
        run_op(3'd3, 32'd5, 32'd0, nb, de, dz);
        lit("dz_busy_cycles", 64'(nb), 64'd1);
        lit("dz_done", 64'(de), 64'd1);
        lit("dz_flag", 64'(dz), 64'd1);
        chk_reg("dz_hi_kept", 1'b1, 32'h1234);
        chk_reg("dz_lo_kept", 1'b0, 32'd14);

        // abort: MULTU 3*4 with LO write in busy cycle 2
        start_op(3'd1, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b1;
        bus.wr_hi   = 1'b0;
        bus.wr_data = 32'hAA;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        lit("abort_busy", 64'(bus.busy), 64'd0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        lit("abort_no_done", 64'(nd), 64'd0);
        chk_reg("abort_lo", 1'b0, 32'hAA);
        chk_reg("abort_hi", 1'b1, 32'h1234);

        // start and write together while idle: write only
        @(posedge clk);
        #2;
        bus.op      = 3'd1;
        bus.in_a    = 32'd3;
        bus.in_b    = 32'd4;
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'h55;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        lit("collide_busy", 64'(bus.busy), 64'd0);
        chk_reg("collide_hi", 1'b1, 32'h55);
        chk_reg("collide_lo", 1'b0, 32'hAA);

        // signed overflow and negative divisor
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, nb, de, dz);
        lit("ovf_dz", 64'(dz), 64'd0);
        chk_reg("ovf_lo", 1'b0, 32'h80000000);
        chk_reg("ovf_hi", 1'b1, 32'h0);
        run_op(3'd4, 32'd7, 32'hFFFFFFFE, nb, de, dz);
        chk_reg("negdiv_lo", 1'b0, 32'hFFFFFFFD);
        chk_reg("negdiv_hi", 1'b1, 32'd1);

        // invalid ops are ignored
        run_op(3'd0, 32'd9, 32'd9, nb, de, dz);
        lit("op0_busy", 64'(nb), 64'd0);
        lit("op0_done", 64'(de), 64'd0);
`ifndef MDU_MACC_EN
        run_op(3'd5, 32'd9, 32'd9, nb, de, dz);
        lit("op5_busy", 64'(nb), 64'd0);
`endif

        // start while busy is dropped
        start_op(3'd1, 32'd6, 32'd7);
        start_op(3'd3, 32'd9, 32'd0);
        wait_idle(nb, de, dz);
        lit("busy_start_remaining", 64'(nb), 64'd3);
        lit("busy_start_no_dz", 64'(dz), 64'd0);
        chk_reg("busy_start_lo", 1'b0, 32'd42);
        chk_reg("busy_start_hi", 1'b1, 32'd0);

`ifdef MDU_MACC_EN
        // accumulate
        write_reg(1'b1, 32'h0);
        write_reg(1'b0, 32'd10);
        run_op(3'd6, 32'd3, 32'd4, nb, de, dz);
        lit("madd_busy_cycles", 64'(nb), 64'd5);
        chk_reg("madd_lo", 1'b0, 32'd22);
        chk_reg("madd_hi", 1'b1, 32'd0);
`endif

        // reset in the middle of a divide
        start_op(3'd3, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        lit("rst_busy", 64'(bus.busy), 64'd0);
        chk_reg("rst_hi", 1'b1, 32'h0);
        chk_reg("rst_lo", 1'b0, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        lit("rst_no_done", 64'(nd), 64'd0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
